acc_flag_stage: RTL



---
 rtl/acc_flag_stage_pkg.sv | 30 +++
 rtl/acc_flag_stage_down_counter.sv | 31 +++
 rtl/acc_flag_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/acc_flag_stage_pkg.sv
// Shared CPU package: datapath widths, stage FSM encoding and ALU op-codes.
package acc_flag_stage_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    // Accumulator stage FSM: IDLE accepts commands, ROT sequences a rotation.
    typedef enum logic {
        StIdle = 1'b0,
        StRot  = 1'b1
    } state_e;

    // Op-codes decoded by the upstream bitwise/arith slice.
    typedef enum logic [2:0] {
        AluAnd  = 3'd0,
        AluOr   = 3'd1,
        AluXor  = 3'd2,
        AluNot  = 3'd3,
        AluAdd  = 3'd4,
        AluSub  = 3'd5,
        AluPass = 3'd6,
        AluInc  = 3'd7
    } alu_op_e;

    // One step of a rotate-left through carry on a {carry, acc} pair.
    function automatic logic [WIDTH:0] rotl_through_carry(input logic [WIDTH:0] v);
        return {v[WIDTH-1:0], v[WIDTH]};
    endfunction

endpackage

// File: rtl/acc_flag_stage_down_counter.sv
// Loadable down-counter that stops at zero; flags the final count.
module acc_flag_stage_down_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // High while the count is on its final step.
    always_comb begin
        last = (count_q == CNT_W'(1));
    end

endmodule

// File: rtl/acc_flag_stage.sv
// Accumulator / flag stage behind the ALU: load, and multi-cycle rotate through carry.
module acc_flag_stage #(
    parameter int unsigned WIDTH = acc_flag_stage_pkg::WIDTH,
    parameter int unsigned CNT_W = acc_flag_stage_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] alu_q,
    input  logic             alu_cout,
    input  logic             wr_en,
    input  logic             rot_en,
    input  logic [CNT_W-1:0] rot_cnt,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    import acc_flag_stage_pkg::state_e;
    import acc_flag_stage_pkg::StIdle;
    import acc_flag_stage_pkg::StRot;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;

    acc_flag_stage_down_counter #(
        .CNT_W(CNT_W)
    ) u_rot_counter (
        .clk     (clk),
        .nrst    (nrst),
        .load    (cnt_load),
        .load_val(rot_cnt),
        .en      (cnt_en),
        .last    (cnt_last)
    );

    // Next-state: command decode in IDLE, one rotate step per cycle in ROT.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_en) begin
                    // Load wins over a simultaneous rotate; the rotate is dropped.
                    acc_d   = alu_q;
                    carry_d = alu_cout;
                    done_d  = 1'b1;
                end else if (rot_en) begin
                    if (rot_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = StRot;
                    end
                end
            end
            StRot: begin
                // Commands are ignored here; only the rotation advances.
                {carry_d, acc_d} = {acc_q, carry_q};
                cnt_en           = 1'b1;
                if (cnt_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Derived from the next acc so the flag always matches the register.
        zero_d = (acc_d == '0);
    end

    // State and flag registers; reset aborts any rotation in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        acc   = acc_q;
        carry = carry_q;
        zero  = zero_q;
        busy  = busy_q;
        done  = done_q;
    end

endmodule
